// File: rtl/food_placer.sv
// rtl/food_placer.sv - clamps a random candidate, rescans the snake for overlap, commits food
// Optional FOOD_TIMEOUT_EN: uneaten food relocates after TIMEOUT_TICKS game ticks.
module food_placer #(
  parameter int CELL          = 10,
  parameter int X_MIN         = 21,
  parameter int X_MAX         = 609,
  parameter int Y_MIN         = 21,
  parameter int Y_MAX         = 449,
  parameter int MAX_TRIES     = 8,
  parameter int FALLBACK_X    = 320,
  parameter int FALLBACK_Y    = 240,
  parameter int TIMEOUT_TICKS = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       spawn,
  input  logic       eat,
  input  logic       tick,
  input  logic [9:0] rand_x,
  input  logic [9:0] rand_y,
  input  logic [7:0] snake_len,
  output logic [7:0] seg_addr,
  input  logic [9:0] seg_x,
  input  logic [9:0] seg_y,
  output logic [9:0] food_x,
  output logic [9:0] food_y,
  output logic       food_valid,
  output logic       busy,
  output logic       placed,
  output logic       fallback_used
);

  typedef enum logic [2:0] {IDLE, LATCH, SCAN, DECIDE, COMMIT} state_t;

  state_t     state_q, state_d;
  logic [9:0] cand_x_q, cand_x_d;
  logic [9:0] cand_y_q, cand_y_d;
  logic [7:0] tries_q, tries_d;
  logic       hit_q, hit_d;
  logic [7:0] len_q, len_d;
  logic [7:0] seg_addr_q, seg_addr_d;
  logic       issue_done_q, issue_done_d;
  logic       rd_valid_q, rd_valid_d;
  logic       rd_last_q, rd_last_d;
  logic       fb_q, fb_d;
  logic [9:0] food_x_q, food_x_d;
  logic [9:0] food_y_q, food_y_d;
  logic       food_valid_q, food_valid_d;
  logic       busy_q, busy_d;
  logic       placed_q, placed_d;
  logic       fallback_used_q, fallback_used_d;
  logic       start_req;

`ifdef FOOD_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;
`else
  logic unused_tick;
  assign unused_tick = tick;
`endif

  logic [9:0]  clamp_x, clamp_y;
  logic [10:0] dx, dy;
  logic        near;
  logic [10:0] step_x, step_y;
  logic [9:0]  next_x, next_y;

  assign clamp_x = (rand_x < 10'(X_MIN)) ? 10'(X_MIN) :
                   (rand_x > 10'(X_MAX)) ? 10'(X_MAX) : rand_x;
  assign clamp_y = (rand_y < 10'(Y_MIN)) ? 10'(Y_MIN) :
                   (rand_y > 10'(Y_MAX)) ? 10'(Y_MAX) : rand_y;

  // seg_x/seg_y belong to the address presented on the previous cycle.
  assign dx = (seg_x >= cand_x_q) ? ({1'b0, seg_x} - {1'b0, cand_x_q})
                                  : ({1'b0, cand_x_q} - {1'b0, seg_x});
  assign dy = (seg_y >= cand_y_q) ? ({1'b0, seg_y} - {1'b0, cand_y_q})
                                  : ({1'b0, cand_y_q} - {1'b0, seg_y});
  assign near = (dx < 11'(CELL)) && (dy < 11'(CELL));

  always_comb begin
    step_x = {1'b0, cand_x_q} + 11'(CELL);
    step_y = {1'b0, cand_y_q};
    if (step_x > 11'(X_MAX)) begin
      step_x = 11'(X_MIN);
      step_y = {1'b0, cand_y_q} + 11'(CELL);
    end
    if (step_y > 11'(Y_MAX)) begin
      step_y = 11'(Y_MIN);
    end
    next_x = step_x[9:0];
    next_y = step_y[9:0];
  end

  always_comb begin
    state_d         = state_q;
    cand_x_d        = cand_x_q;
    cand_y_d        = cand_y_q;
    tries_d         = tries_q;
    hit_d           = hit_q;
    len_d           = len_q;
    seg_addr_d      = seg_addr_q;
    issue_done_d    = issue_done_q;
    rd_valid_d      = rd_valid_q;
    rd_last_d       = rd_last_q;
    fb_d            = fb_q;
    food_x_d        = food_x_q;
    food_y_d        = food_y_q;
    food_valid_d    = food_valid_q;
    fallback_used_d = fallback_used_q;
    placed_d        = 1'b0;
    start_req       = 1'b0;
`ifdef FOOD_TIMEOUT_EN
    tmo_d           = tmo_q;
`endif

    case (state_q)
      IDLE: begin
        start_req = spawn | eat;
`ifdef FOOD_TIMEOUT_EN
        if (start_req) begin
          tmo_d = '0;
        end else if (food_valid_q && tick) begin
          if (tmo_q == 16'(TIMEOUT_TICKS - 1)) begin
            tmo_d     = '0;
            start_req = 1'b1;
          end else begin
            tmo_d = tmo_q + 16'd1;
          end
        end
`endif
        if (start_req) state_d = LATCH;
        if (eat) food_valid_d = 1'b0;
      end

      LATCH: begin
        cand_x_d     = clamp_x;
        cand_y_d     = clamp_y;
        tries_d      = '0;
        hit_d        = 1'b0;
        fb_d         = 1'b0;
        len_d        = snake_len;
        seg_addr_d   = '0;
        issue_done_d = 1'b0;
        rd_valid_d   = 1'b0;
        rd_last_d    = 1'b0;
        state_d      = (snake_len == 8'd0) ? COMMIT : SCAN;
      end

      SCAN: begin
        // Address issue runs one cycle ahead of the compare pipeline.
        rd_valid_d = !issue_done_q;
        rd_last_d  = (seg_addr_q == len_q - 8'd1);
        if (!issue_done_q) begin
          if (seg_addr_q == len_q - 8'd1) issue_done_d = 1'b1;
          else                            seg_addr_d   = seg_addr_q + 8'd1;
        end
        if (rd_valid_q) begin
          hit_d = hit_q | near;
          if (rd_last_q) state_d = DECIDE;
        end
      end

      DECIDE: begin
        if (!hit_q) begin
          state_d = COMMIT;
        end else if (tries_q == 8'(MAX_TRIES - 1)) begin
          cand_x_d = 10'(FALLBACK_X);
          cand_y_d = 10'(FALLBACK_Y);
          fb_d     = 1'b1;
          state_d  = COMMIT;
        end else begin
          cand_x_d     = next_x;
          cand_y_d     = next_y;
          tries_d      = tries_q + 8'd1;
          hit_d        = 1'b0;
          seg_addr_d   = '0;
          issue_done_d = 1'b0;
          rd_valid_d   = 1'b0;
          rd_last_d    = 1'b0;
          state_d      = SCAN;
        end
      end

      COMMIT: begin
        food_x_d        = cand_x_q;
        food_y_d        = cand_y_q;
        food_valid_d    = 1'b1;
        placed_d        = 1'b1;
        fallback_used_d = fb_q;
`ifdef FOOD_TIMEOUT_EN
        tmo_d           = '0;
`endif
        state_d         = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      cand_x_q        <= '0;
      cand_y_q        <= '0;
      tries_q         <= '0;
      hit_q           <= 1'b0;
      len_q           <= '0;
      seg_addr_q      <= '0;
      issue_done_q    <= 1'b0;
      rd_valid_q      <= 1'b0;
      rd_last_q       <= 1'b0;
      fb_q            <= 1'b0;
      food_x_q        <= '0;
      food_y_q        <= '0;
      food_valid_q    <= 1'b0;
      busy_q          <= 1'b0;
      placed_q        <= 1'b0;
      fallback_used_q <= 1'b0;
`ifdef FOOD_TIMEOUT_EN
      tmo_q           <= '0;
`endif
    end else begin
      state_q         <= state_d;
      cand_x_q        <= cand_x_d;
      cand_y_q        <= cand_y_d;
      tries_q         <= tries_d;
      hit_q           <= hit_d;
      len_q           <= len_d;
      seg_addr_q      <= seg_addr_d;
      issue_done_q    <= issue_done_d;
      rd_valid_q      <= rd_valid_d;
      rd_last_q       <= rd_last_d;
      fb_q            <= fb_d;
      food_x_q        <= food_x_d;
      food_y_q        <= food_y_d;
      food_valid_q    <= food_valid_d;
      busy_q          <= busy_d;
      placed_q        <= placed_d;
      fallback_used_q <= fallback_used_d;
`ifdef FOOD_TIMEOUT_EN
      tmo_q           <= tmo_d;
`endif
    end
  end

  assign seg_addr      = seg_addr_q;
  assign food_x        = food_x_q;
  assign food_y        = food_y_q;
  assign food_valid    = food_valid_q;
  assign busy          = busy_q;
  assign placed        = placed_q;
  assign fallback_used = fallback_used_q;

endmodule

// File: tb/tb_food_placer.sv
// tb/tb_food_placer.sv - randomized self-checking bench for food_placer against a placement model
module tb_food_placer;

  logic       clock = 1'b0;
  logic       reset, spawn, eat, tick;
  logic [9:0] rand_x, rand_y;
  logic [7:0] snake_len;
  logic [7:0] seg_addr;
  logic [9:0] seg_x, seg_y;
  logic [9:0] food_x, food_y;
  logic       food_valid, busy, placed, fallback_used;

  logic [9:0] mx [256];
  logic [9:0] my [256];
  int         addr_log [64];
  int         n_tests = 0;
  int         n_fail  = 0;

  food_placer dut (
    .clock(clock), .reset(reset), .spawn(spawn), .eat(eat), .tick(tick),
    .rand_x(rand_x), .rand_y(rand_y), .snake_len(snake_len),
    .seg_addr(seg_addr), .seg_x(seg_x), .seg_y(seg_y),
    .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
    .busy(busy), .placed(placed), .fallback_used(fallback_used)
  );

  always #5 clock = ~clock;

  // Synchronous segment memory: data follows the address by one cycle.
  always @(posedge clock) begin
    seg_x <= mx[seg_addr];
    seg_y <= my[seg_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int absi(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Placement rules restated directly: try candidates, step on overlap, fallback at the end.
  task automatic model(input int rx, input int ry, input int len,
                       output int ex, output int ey, output int efb, output int elat);
    int cx, cy, t;
    bit hit;
    cx = clampi(rx, 21, 609);
    cy = clampi(ry, 21, 449);
    efb = 0;
    t = 0;
    forever begin
      hit = 0;
      for (int i = 0; i < len; i++)
        if (absi(int'(mx[i]) - cx) < 10 && absi(int'(my[i]) - cy) < 10) hit = 1;
      if (!hit) break;
      if (t == 7) begin
        cx = 320; cy = 240; efb = 1;
        break;
      end
      cx += 10;
      if (cx > 609) begin
        cx = 21; cy += 10;
      end
      if (cy > 449) cy = 21;
      t++;
    end
    ex = cx;
    ey = cy;
    elat = (len == 0) ? 3 : (len + 5) + t * (len + 2);
  endtask

  // Called just after a falling edge; returns the cycle on which placed was seen high.
  task automatic run_place(input bit sp, input bit et, input bit scr, output int lat);
    int  n;
    bit  done;
    spawn = sp;
    eat   = et;
    @(negedge clock);
    n = 1;
    spawn = 1'b0;
    eat   = 1'b0;
    addr_log[1] = int'(seg_addr);
    check("busy_start", busy, 1);
    if (et) check("valid_clear", food_valid, 0);
    done = 0;
    lat  = -1;
    while (!done && n < 3000) begin
      @(negedge clock);
      n++;
      if (n < 64) addr_log[n] = int'(seg_addr);
      if (placed) begin
        lat = n;
        done = 1;
        spawn = 1'b0;
        eat   = 1'b0;
      end else if (scr) begin
        rand_x    = 10'($urandom);
        rand_y    = 10'($urandom);
        snake_len = 8'($urandom);
        spawn     = 1'($urandom_range(0, 1));
        eat       = 1'($urandom_range(0, 1));
      end
    end
    spawn = 1'b0;
    eat   = 1'b0;
    if (!done) check("place_timeout", 0, 1);
  endtask

  initial begin
    int lat, pc, ex, ey, efb, elat;
    reset = 1'b1; spawn = 1'b0; eat = 1'b0; tick = 1'b0;
    rand_x = '0; rand_y = '0; snake_len = '0;
    for (int i = 0; i < 256; i++) begin
      mx[i] = 10'd1000;
      my[i] = 10'd1000;
    end
    repeat (3) @(negedge clock);
    check("rst_food_x", food_x, 0);
    check("rst_food_y", food_y, 0);
    check("rst_valid", food_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_placed", placed, 0);
    check("rst_fallback", fallback_used, 0);
    check("rst_seg_addr", seg_addr, 0);
    reset = 1'b0;
    @(negedge clock);

    rand_x = 10'd100; rand_y = 10'd200; snake_len = 8'd0;
    run_place(1, 0, 0, lat);
    check("t1_lat", lat, 3);
    check("t1_x", food_x, 100);
    check("t1_y", food_y, 200);
    check("t1_valid", food_valid, 1);
    check("t1_fb", fallback_used, 0);

    rand_x = 10'd5; rand_y = 10'd470;
    run_place(0, 1, 0, lat);
    check("t2_x", food_x, 21);
    check("t2_y", food_y, 449);
    check("t2_lat", lat, 3);

    for (int i = 0; i < 4; i++) begin
      mx[i] = 10'(300 + 10 * i);
      my[i] = 10'd300;
    end
    rand_x = 10'd100; rand_y = 10'd100; snake_len = 8'd4;
    run_place(0, 1, 0, lat);
    check("t3_lat", lat, 9);
    for (int k = 0; k < 4; k++) check("t3_addr", addr_log[k + 2], k);
    check("t3_x", food_x, 100);
    check("t3_y", food_y, 100);

    mx[0] = 10'd605; my[0] = 10'd100;
    rand_x = 10'd609; rand_y = 10'd100; snake_len = 8'd1;
    run_place(0, 1, 0, lat);
    check("t4_x", food_x, 21);
    check("t4_y", food_y, 110);
    check("t4_lat", lat, 9);

    for (int i = 0; i < 8; i++) begin
      mx[i] = 10'(100 + 10 * i);
      my[i] = 10'd100;
    end
    rand_x = 10'd100; rand_y = 10'd100; snake_len = 8'd8;
    run_place(0, 1, 0, lat);
    check("t5_x", food_x, 320);
    check("t5_y", food_y, 240);
    check("t5_fb", fallback_used, 1);
    check("t5_lat", lat, 83);
    rand_x = 10'd50; rand_y = 10'd50; snake_len = 8'd0;
    run_place(0, 1, 0, lat);
    check("t5_fb_clear", fallback_used, 0);

    rand_x = 10'd400; rand_y = 10'd400; snake_len = 8'd8;
    eat = 1'b1;
    repeat (3) @(negedge clock);
    eat = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("t6_busy", busy, 0);
    check("t6_valid", food_valid, 0);
    pc = 0;
    repeat (30) begin
      @(negedge clock);
      if (placed) pc++;
    end
    check("t6_no_place", pc, 0);

    rand_x = 10'd200; rand_y = 10'd300; snake_len = 8'd0;
    run_place(1, 0, 0, lat);
    rand_x = 10'd400; rand_y = 10'd100;
    pc = 0;
    repeat (9) begin
      tick = 1'b1;
      @(negedge clock);
      tick = 1'b0;
      if (placed) pc++;
      @(negedge clock);
      if (placed) pc++;
    end
    check("tmo_early", pc, 0);
`ifdef FOOD_TIMEOUT_EN
    begin
      int n;
      int bad;
      tick = 1'b1;
      @(negedge clock);
      tick = 1'b0;
      n = 1;
      bad = 0;
      while (!placed && n < 200) begin
        if (!food_valid) bad++;
        @(negedge clock);
        n++;
      end
      check("tmo_lat", n, 3);
      check("tmo_valid_held", bad, 0);
      check("tmo_x", food_x, 400);
      check("tmo_y", food_y, 100);
    end
`else
    repeat (3) begin
      tick = 1'b1;
      @(negedge clock);
      tick = 1'b0;
      if (placed) pc++;
      @(negedge clock);
      if (placed) pc++;
    end
    check("notmo_place", pc, 0);
    check("notmo_x", food_x, 200);
    check("notmo_y", food_y, 300);
`endif

    for (int it = 0; it < 40; it++) begin
      int rx, ry, len, bx, by, mode;
      rx  = int'($urandom_range(0, 1023));
      ry  = int'($urandom_range(0, 1023));
      len = int'($urandom_range(0, 12));
      bx  = clampi(rx, 21, 609);
      by  = clampi(ry, 21, 449);
      for (int i = 0; i < len; i++) begin
        mx[i] = 10'(bx + int'($urandom_range(0, 60)) - 10);
        my[i] = 10'(by + int'($urandom_range(0, 24)) - 10);
      end
      rand_x = 10'(rx); rand_y = 10'(ry); snake_len = 8'(len);
      model(rx, ry, len, ex, ey, efb, elat);
      mode = int'($urandom_range(0, 2));
      run_place(mode != 1, mode != 0, 1, lat);
      check("rnd_x", food_x, ex);
      check("rnd_y", food_y, ey);
      check("rnd_fb", fallback_used, efb);
      check("rnd_lat", lat, elat);
      check("rnd_valid", food_valid, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
